// File: rtl/keccak_sponge_ctrl.sv
// keccak_sponge_ctrl -- host-side sequencer for the keccak core.
//
// Packs a byte-granular message stream into rate-sized blocks of N-bit lanes
// and feeds them to the core. It applies Keccak multi-rate padding (pad10*1),
// pulses Last_block, captures OUT_WORDS digest lanes and re-streams them on
// a valid/ready output.
//
// Optional feature: define KECCAK_SHA3_PAD_EN to use the SHA-3 domain pad
// byte 0x06 instead of the original Keccak 0x01. The 0x80 terminator is the
// same in both builds.
//
// Ports
//   Clock, Reset_n                  clock, asynchronous active-low reset
//   Msg_data/bytes/last/valid/ready message lane stream (byte i = bits 8i+7:8i)
//   Start, Din, Din_valid           core start pulse and absorbed lanes
//   Last_block                      core finalise pulse
//   Buffer_full, Ready              core back-pressure / absorb-complete
//   Dout, Dout_valid                core digest lanes
//   Hash_data/valid/last/ready      digest lane stream to the consumer
//   Busy                            message in flight
module keccak_sponge_ctrl #(
  parameter int N          = 64,
  parameter int RATE_WORDS = 17,
  parameter int OUT_WORDS  = 4
) (
  input  logic                 Clock,
  input  logic                 Reset_n,
  input  logic [N-1:0]         Msg_data,
  input  logic [$clog2(N/8):0] Msg_bytes,
  input  logic                 Msg_last,
  input  logic                 Msg_valid,
  output logic                 Msg_ready,
  output logic                 Start,
  output logic [N-1:0]         Din,
  output logic                 Din_valid,
  output logic                 Last_block,
  input  logic                 Buffer_full,
  input  logic                 Ready,
  input  logic [N-1:0]         Dout,
  input  logic                 Dout_valid,
  output logic [N-1:0]         Hash_data,
  output logic                 Hash_valid,
  output logic                 Hash_last,
  input  logic                 Hash_ready,
  output logic                 Busy
);

  localparam int NB = N / 8;
  localparam int BW = $clog2(NB) + 1;
  localparam int CW = (RATE_WORDS > 1) ? $clog2(RATE_WORDS) : 1;
  localparam int OW = (OUT_WORDS > 1) ? $clog2(OUT_WORDS) : 1;
  localparam logic [CW-1:0] LAST_WORD  = CW'(RATE_WORDS - 1);
  localparam logic [OW-1:0] LAST_OUT   = OW'(OUT_WORDS - 1);
  localparam logic [BW-1:0] FULL_BYTES = BW'(NB);
  localparam logic [N-1:0]  PAD_LAST   = {8'h80, {(N-8){1'b0}}};
`ifdef KECCAK_SHA3_PAD_EN
  localparam logic [7:0]    PAD_FIRST  = 8'h06;
`else
  localparam logic [7:0]    PAD_FIRST  = 8'h01;
`endif

  typedef enum logic [2:0] {
    IDLE, BLKWAIT, ABSORB, PAD, FINWAIT, SQUEEZE, DRAIN
  } state_t;

  state_t        state_reg, state_next;
  logic [CW-1:0] word_cnt_reg, word_cnt_next;
  logic [OW-1:0] out_idx_reg, out_idx_next;
  logic          pad_first_reg, pad_first_next;  // first pad byte still owed to a later lane
  logic [N-1:0]  din_reg, din_next;
  logic          din_valid_reg, din_valid_next;
  logic          start_reg, start_next;
  logic          last_block_reg, last_block_next;

  logic [BW-1:0] bytes_clamped;
  logic          last_full;
  logic [N-1:0]  last_lane;
  logic [N-1:0]  digest_word [OUT_WORDS];

  // Final message lane: keep bytes below b, place the pad byte at b, zero the rest.
  always_comb begin
    bytes_clamped = (Msg_bytes > FULL_BYTES) ? FULL_BYTES : Msg_bytes;
    last_full     = (bytes_clamped == FULL_BYTES);
    last_lane     = '0;
    for (int i = 0; i < NB; i++) begin
      if (BW'(i) < bytes_clamped)
        last_lane[8*i +: 8] = Msg_data[8*i +: 8];
      else if (BW'(i) == bytes_clamped)
        last_lane[8*i +: 8] = PAD_FIRST;
    end
  end

  // State register
  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      state_reg      <= IDLE;
      word_cnt_reg   <= '0;
      out_idx_reg    <= '0;
      pad_first_reg  <= 1'b0;
      din_reg        <= '0;
      din_valid_reg  <= 1'b0;
      start_reg      <= 1'b0;
      last_block_reg <= 1'b0;
    end else begin
      state_reg      <= state_next;
      word_cnt_reg   <= word_cnt_next;
      out_idx_reg    <= out_idx_next;
      pad_first_reg  <= pad_first_next;
      din_reg        <= din_next;
      din_valid_reg  <= din_valid_next;
      start_reg      <= start_next;
      last_block_reg <= last_block_next;
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (Msg_valid) state_next = BLKWAIT;
      // A full final lane at the end of a block leaves the pad byte owed to a
      // fresh block, so BLKWAIT resumes into PAD instead of ABSORB.
      BLKWAIT: if (!Buffer_full) state_next = pad_first_reg ? PAD : ABSORB;
      ABSORB: begin
        if (Msg_valid) begin
          if (Msg_last) begin
            if (word_cnt_reg == LAST_WORD) state_next = last_full ? BLKWAIT : FINWAIT;
            else                           state_next = PAD;
          end else if (word_cnt_reg == LAST_WORD) begin
            state_next = BLKWAIT;
          end
        end
      end
      PAD:     if (word_cnt_reg == LAST_WORD) state_next = FINWAIT;
      FINWAIT: if (Ready) state_next = SQUEEZE;
      SQUEEZE: if (Dout_valid && out_idx_reg == LAST_OUT) state_next = DRAIN;
      DRAIN:   if (Hash_ready && out_idx_reg == LAST_OUT) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Datapath / registered-output next values
  always_comb begin
    word_cnt_next   = word_cnt_reg;
    out_idx_next    = out_idx_reg;
    pad_first_next  = pad_first_reg;
    din_next        = '0;
    din_valid_next  = 1'b0;
    start_next      = (state_reg == IDLE) && Msg_valid;
    last_block_next = (state_reg == FINWAIT) && Ready;
    case (state_reg)
      ABSORB: begin
        if (Msg_valid) begin
          din_valid_next = 1'b1;
          if (Msg_last) begin
            din_next       = last_lane;
            pad_first_next = last_full;
          end else begin
            din_next = Msg_data;
          end
          if (word_cnt_reg == LAST_WORD) begin
            // Terminator only lands here if the pad byte did too.
            if (Msg_last && !last_full) din_next = din_next | PAD_LAST;
            word_cnt_next = '0;
          end else begin
            word_cnt_next = word_cnt_reg + CW'(1);
          end
        end
      end
      PAD: begin
        din_valid_next = 1'b1;
        din_next       = pad_first_reg ? N'(PAD_FIRST) : '0;
        pad_first_next = 1'b0;
        if (word_cnt_reg == LAST_WORD) begin
          din_next      = din_next | PAD_LAST;
          word_cnt_next = '0;
        end else begin
          word_cnt_next = word_cnt_reg + CW'(1);
        end
      end
      SQUEEZE: begin
        if (Dout_valid) out_idx_next = (out_idx_reg == LAST_OUT) ? '0 : out_idx_reg + OW'(1);
      end
      DRAIN: begin
        if (Hash_ready) out_idx_next = (out_idx_reg == LAST_OUT) ? '0 : out_idx_reg + OW'(1);
      end
      default: ;
    endcase
  end

  // Digest capture buffer, one register per captured lane
  for (genvar gi = 0; gi < OUT_WORDS; gi++) begin : g_digest
    logic [N-1:0] word_reg;
    always_ff @(posedge Clock or negedge Reset_n) begin
      if (!Reset_n)
        word_reg <= '0;
      else if (state_reg == SQUEEZE && Dout_valid && out_idx_reg == OW'(gi))
        word_reg <= Dout;
    end
    assign digest_word[gi] = word_reg;
  end

  // Outputs
  always_comb begin
    Msg_ready  = (state_reg == ABSORB);
    Busy       = (state_reg != IDLE);
    Start      = start_reg;
    Din        = din_reg;
    Din_valid  = din_valid_reg;
    Last_block = last_block_reg;
    Hash_valid = (state_reg == DRAIN);
    Hash_last  = (state_reg == DRAIN) && (out_idx_reg == LAST_OUT);
    Hash_data  = (state_reg == DRAIN) ? digest_word[out_idx_reg] : '0;
  end

endmodule

// File: tb/tb_keccak_sponge_ctrl.sv
// Bench for keccak_sponge_ctrl: directed table of messages, a reset-abort
// sequence and randomized messages, all checked against a byte-level
// pad10*1 reference model and a scripted core / digest consumer.
module tb_keccak_sponge_ctrl;
  localparam int N          = 64;
  localparam int RATE_WORDS = 17;
  localparam int OUT_WORDS  = 4;
  localparam int RB         = RATE_WORDS * 8;
`ifdef KECCAK_SHA3_PAD_EN
  localparam logic [7:0] PADB = 8'h06;
`else
  localparam logic [7:0] PADB = 8'h01;
`endif

  logic          Clock = 1'b0;
  logic          Reset_n = 1'b0;
  logic [N-1:0]  Msg_data = '0;
  logic [3:0]    Msg_bytes = '0;
  logic          Msg_last = 1'b0;
  logic          Msg_valid = 1'b0;
  logic          Msg_ready;
  logic          Start;
  logic [N-1:0]  Din;
  logic          Din_valid;
  logic          Last_block;
  logic          Buffer_full = 1'b0;
  logic          Ready = 1'b0;
  logic [N-1:0]  Dout = '0;
  logic          Dout_valid = 1'b0;
  logic [N-1:0]  Hash_data;
  logic          Hash_valid;
  logic          Hash_last;
  logic          Hash_ready = 1'b0;
  logic          Busy;

  keccak_sponge_ctrl #(.N(N), .RATE_WORDS(RATE_WORDS), .OUT_WORDS(OUT_WORDS)) dut (
    .Clock(Clock), .Reset_n(Reset_n),
    .Msg_data(Msg_data), .Msg_bytes(Msg_bytes), .Msg_last(Msg_last),
    .Msg_valid(Msg_valid), .Msg_ready(Msg_ready),
    .Start(Start), .Din(Din), .Din_valid(Din_valid), .Last_block(Last_block),
    .Buffer_full(Buffer_full), .Ready(Ready), .Dout(Dout), .Dout_valid(Dout_valid),
    .Hash_data(Hash_data), .Hash_valid(Hash_valid), .Hash_last(Hash_last),
    .Hash_ready(Hash_ready), .Busy(Busy)
  );

  always #5 Clock = ~Clock;

  int vectors = 0;
  int errors  = 0;
  logic [63:0] din_got[$];
  logic [63:0] exp_lanes[$];

  typedef struct {
    int          nbytes;
    int          fill;      // 1: all-0xFF message, 0: random bytes
    int          bf_stall;  // Buffer_full cycles at each block boundary
    int          hr_stall;  // Hash_ready low cycles at start of drain
    int          exp_lanes;
    int          a_idx;
    logic [63:0] a_val;
    int          b_idx;
    logic [63:0] b_val;
  } vec_t;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic run_msg(input int nbytes, input int fill, input int bf_stall,
                         input int hr_stall, input bit gaps);
    byte unsigned msg[$];
    byte unsigned pb[$];
    logic [63:0]  dig[OUT_WORDS];
    logic [63:0]  w, prev_hd;
    int nl, plen, li, hk, dk, extra, bf_cnt, hs_cnt, rdy_dly, rem, starts, lbs, cyc;
    bit mf_pend, hf_pend, bf_prev, start_seen, lb_seen, prev_hv, prev_hr, prev_hl, done;

    // Reference model: byte-level pad10*1 to a multiple of the rate
    for (int i = 0; i < nbytes + 8; i++) msg.push_back(fill != 0 ? 8'hFF : 8'($urandom));
    plen = (nbytes / RB + 1) * RB;
    for (int i = 0; i < plen; i++) pb.push_back(i < nbytes ? msg[i] : 8'h00);
    pb[nbytes]  = pb[nbytes] | PADB;
    pb[plen-1]  = pb[plen-1] | 8'h80;
    exp_lanes.delete();
    for (int l = 0; l < plen / 8; l++) begin
      for (int b = 0; b < 8; b++) w[8*b +: 8] = pb[8*l + b];
      exp_lanes.push_back(w);
    end
    for (int k = 0; k < OUT_WORDS; k++) dig[k] = {$urandom, $urandom};

    din_got.delete();
    nl = (nbytes == 0) ? 1 : (nbytes + 7) / 8;
    li = 0; hk = 0; dk = 0; extra = 0; starts = 0; lbs = 0;
    bf_cnt = bf_stall; hs_cnt = hr_stall; rdy_dly = $urandom_range(3);
    mf_pend = 0; hf_pend = 0; bf_prev = 0; start_seen = 0; lb_seen = 0;
    prev_hv = 0; prev_hr = 0; prev_hl = 0; prev_hd = '0; done = 0;
    Msg_valid = 0;

    for (cyc = 0; cyc < 4000 && !done; cyc++) begin
      @(negedge Clock);
      // handshakes committed at the edge just passed
      if (mf_pend) li++;
      if (hf_pend) hk++;

      // observe
      if (Start) begin starts++; start_seen = 1; end
      if (bf_prev) begin
        chk("bf_hold_din_valid", 64'(Din_valid), 64'(0));
        chk("bf_hold_msg_ready", 64'(Msg_ready), 64'(0));
      end
      if (Din_valid) begin
        if (din_got.size() < exp_lanes.size())
          chk($sformatf("din_lane%0d", din_got.size()), Din, exp_lanes[din_got.size()]);
        else
          chk("din_lane_overflow", 64'(din_got.size() + 1), 64'(exp_lanes.size()));
        din_got.push_back(Din);
        if (din_got.size() % RATE_WORDS == 0) bf_cnt = bf_stall;
      end
      if (Last_block) begin
        lbs++; lb_seen = 1;
        chk("lanes_before_last_block", 64'(din_got.size()), 64'(exp_lanes.size()));
      end
      chk("busy", 64'(Busy), 64'(start_seen && hk < OUT_WORDS));
      if (prev_hv && !prev_hr) begin
        chk("hash_hold_valid", 64'(Hash_valid), 64'(1));
        chk("hash_hold_data", Hash_data, prev_hd);
        chk("hash_hold_last", 64'(Hash_last), 64'(prev_hl));
      end

      if (hk == OUT_WORDS) begin
        done = 1;
        Msg_valid = 0; Hash_ready = 0; Dout_valid = 0; Ready = 0; Buffer_full = 0;
      end else begin
        // message producer (lane held until accepted)
        if (li < nl) begin
          if (mf_pend || !Msg_valid) begin
            Msg_valid = !gaps || ($urandom_range(3) != 0);
            for (int b = 0; b < 8; b++) Msg_data[8*b +: 8] = msg[8*li + b];
            Msg_last = (li == nl - 1);
            if (li == nl - 1) begin
              rem = nbytes - 8 * li;
              Msg_bytes = (rem == 8) ? 4'($urandom_range(15, 8)) : 4'(rem);
            end else begin
              Msg_bytes = 4'($urandom_range(15));
            end
          end
        end else begin
          Msg_valid = 0;
        end
        // core model
        Buffer_full = (bf_cnt > 0);
        if (bf_cnt > 0) bf_cnt--;
        bf_prev = Buffer_full;
        if (din_got.size() == exp_lanes.size() && !lb_seen) begin
          if (rdy_dly > 0) begin rdy_dly--; Ready = 0; end
          else Ready = 1;
        end else begin
          Ready = 0;
        end
        if (lb_seen && dk < OUT_WORDS) begin
          Dout_valid = ($urandom_range(2) != 0);
          if (Dout_valid) begin Dout = dig[dk]; dk++; end
        end else if (lb_seen && extra < 2) begin
          Dout_valid = 1; Dout = ~dig[extra]; extra++;
        end else begin
          Dout_valid = 0;
        end
        // digest consumer
        if (Hash_valid && hs_cnt > 0) begin Hash_ready = 0; hs_cnt--; end
        else Hash_ready = gaps ? ($urandom_range(3) != 0) : 1'b1;

        mf_pend = Msg_valid && Msg_ready;
        hf_pend = Hash_valid && Hash_ready;
        if (hf_pend) begin
          if (hk < OUT_WORDS) begin
            chk($sformatf("hash_data%0d", hk), Hash_data, dig[hk]);
            chk($sformatf("hash_last%0d", hk), 64'(Hash_last), 64'(hk == OUT_WORDS - 1));
          end else begin
            chk("hash_lane_overflow", 64'(hk + 1), 64'(OUT_WORDS));
          end
        end
        prev_hv = Hash_valid; prev_hr = Hash_ready; prev_hd = Hash_data; prev_hl = Hash_last;
      end
    end

    chk("completion", 64'(hk), 64'(OUT_WORDS));
    chk("start_pulses", 64'(starts), 64'(1));
    chk("last_block_pulses", 64'(lbs), 64'(1));
    chk("din_lane_total", 64'(din_got.size()), 64'(exp_lanes.size()));
    $display("msg %0d bytes: %0d lanes out, %0d expected, %0d cycles", nbytes,
             din_got.size(), exp_lanes.size(), cyc);
  endtask

  initial begin
    vec_t vt[6];
    int cnt;

    vt[0] = '{0,   0, 0,  0, 17, 0,  {56'h0, PADB}, 16, 64'h8000000000000000};
    vt[1] = '{136, 0, 0,  0, 34, 17, {56'h0, PADB}, 33, 64'h8000000000000000};
    vt[2] = '{135, 1, 0,  0, 17, 16, {PADB | 8'h80, 56'hFFFFFFFFFFFFFF}, 0, 64'hFFFFFFFFFFFFFFFF};
    vt[3] = '{200, 0, 10, 0, 34, 25, {56'h0, PADB}, 33, 64'h8000000000000000};
    vt[4] = '{20,  1, 0,  5, 17, 2,  {24'h0, PADB, 32'hFFFFFFFF}, 16, 64'h8000000000000000};
    vt[5] = '{128, 1, 3,  2, 17, 16, {8'h80, 48'h0, PADB}, 15, 64'hFFFFFFFFFFFFFFFF};

    // reset state
    #12;
    chk("reset_flags", 64'({Start, Din_valid, Last_block, Msg_ready, Hash_valid, Hash_last, Busy}), 64'(0));
    chk("reset_din", Din, 64'(0));
    chk("reset_hash_data", Hash_data, 64'(0));
    @(negedge Clock);
    Reset_n = 1;

    for (int i = 0; i < 6; i++) begin
      run_msg(vt[i].nbytes, vt[i].fill, vt[i].bf_stall, vt[i].hr_stall, 1'b0);
      chk($sformatf("vec%0d_lanes", i), 64'(din_got.size()), 64'(vt[i].exp_lanes));
      if (din_got.size() > vt[i].a_idx) chk($sformatf("vec%0d_lane%0d", i, vt[i].a_idx), din_got[vt[i].a_idx], vt[i].a_val);
      if (din_got.size() > vt[i].b_idx) chk($sformatf("vec%0d_lane%0d", i, vt[i].b_idx), din_got[vt[i].b_idx], vt[i].b_val);
    end

    // Reset asserted in ABSORB at lane 9
    Msg_data = 64'h0123456789ABCDEF; Msg_bytes = 4'd8; Msg_last = 0; Msg_valid = 1;
    Buffer_full = 0; Ready = 0; Hash_ready = 0; Dout_valid = 0;
    cnt = 0;
    for (int c = 0; c < 100 && cnt < 9; c++) begin
      @(negedge Clock);
      if (Din_valid) cnt++;
    end
    chk("abort_lane_count", 64'(cnt), 64'(9));
    chk("abort_in_absorb", 64'(Msg_ready), 64'(1));
    #2 Reset_n = 0;
    #1;
    chk("abort_flags", 64'({Start, Din_valid, Last_block, Msg_ready, Hash_valid, Hash_last, Busy}), 64'(0));
    chk("abort_din", Din, 64'(0));
    Msg_valid = 0;
    $display("reset abort after %0d lanes", cnt);
    @(negedge Clock);
    Reset_n = 1;
    run_msg(20, 0, 0, 0, 1'b0);

    // randomized messages
    for (int r = 0; r < 25; r++)
      run_msg($urandom_range(300), 0, $urandom_range(4), $urandom_range(3), 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
